// File: rtl/rv64_alu_reg.sv
// rv64_alu_reg: registered RV64I integer ALU for the execute stage.
// Decodes R-type funct3/funct7[5] into ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
// Comparison flags for branch resolution are computed every cycle from the
// operands, independent of the selected operation.
// All outputs are registered (one-cycle latency). Reset is synchronous and active-high.
//
// Ports:
//   clk, reset        clock (rising edge) / synchronous active-high reset
//   in_valid          operands and funct fields valid this cycle
//   input_a, input_b  rs1 / rs2 operands
//   funct3, funct7    instr[14:12] / instr[31:25]
//   out_valid         registered in_valid
//   result            operation result
//   flag_overflow     signed overflow of ADD/SUB, 0 otherwise
//   flag_equal/not_equal/greater/less           signed comparison of a and b
//   flag_u_equal/u_greater/u_less               unsigned comparison of a and b
module rv64_alu_reg #(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WORDSIZE-1:0] input_a,
  input  logic [WORDSIZE-1:0] input_b,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  output logic                out_valid,
  output logic [WORDSIZE-1:0] result,
  output logic                flag_overflow,
  output logic                flag_equal,
  output logic                flag_not_equal,
  output logic                flag_greater,
  output logic                flag_less,
  output logic                flag_u_equal,
  output logic                flag_u_greater,
  output logic                flag_u_less
);

  localparam int SHW = $clog2(WORDSIZE);
  localparam int MSB = WORDSIZE - 1;

  logic [SHW-1:0]      shamt;
  logic [WORDSIZE-1:0] sum;
  logic [WORDSIZE-1:0] diff;
  logic                eq;
  logic                slt;
  logic                ult;

  logic [WORDSIZE-1:0] result_d, result_q;
  logic                ovf_d, ovf_q;
  logic [6:0]          cmp_d, cmp_q;  // {eq, ne, gt, lt, ueq, ugt, ult}
  logic                valid_q;

  assign shamt = input_b[SHW-1:0];
  assign sum   = input_a + input_b;
  assign diff  = input_a - input_b;
  assign eq    = (input_a == input_b);
  assign slt   = ($signed(input_a) < $signed(input_b));
  assign ult   = (input_a < input_b);

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    case (funct3)
      3'b000: begin
        if (funct7[5]) begin
          result_d = diff;
          ovf_d    = (input_a[MSB] != input_b[MSB]) && (diff[MSB] != input_a[MSB]);
        end else begin
          result_d = sum;
          ovf_d    = (input_a[MSB] == input_b[MSB]) && (sum[MSB] != input_a[MSB]);
        end
      end
      3'b001: result_d = input_a << shamt;
      3'b010: result_d = {{(WORDSIZE-1){1'b0}}, slt};
      3'b011: result_d = {{(WORDSIZE-1){1'b0}}, ult};
      3'b100: result_d = input_a ^ input_b;
      3'b101: begin
        if (funct7[5]) result_d = $unsigned($signed(input_a) >>> shamt);
        else           result_d = input_a >> shamt;
      end
      3'b110: result_d = input_a | input_b;
      default: result_d = input_a & input_b;
    endcase
  end

  // Greater is derived so each triple is one-hot by construction.
  always_comb begin
    cmp_d = {eq, ~eq, ~eq & ~slt, slt, eq, ~eq & ~ult, ult};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cmp_q    <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        cmp_q    <= cmp_d;
      end
    end
  end

  assign out_valid      = valid_q;
  assign result         = result_q;
  assign flag_overflow  = ovf_q;
  assign flag_equal     = cmp_q[6];
  assign flag_not_equal = cmp_q[5];
  assign flag_greater   = cmp_q[4];
  assign flag_less      = cmp_q[3];
  assign flag_u_equal   = cmp_q[2];
  assign flag_u_greater = cmp_q[1];
  assign flag_u_less    = cmp_q[0];

endmodule

// File: tb/tb_rv64_alu_reg.sv
// Testbench for rv64_alu_reg: directed cases plus randomized operations,
// checked against a behavioural model of the RV64I R-type rules.
module tb_rv64_alu_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] input_a = '0;
  logic [63:0] input_b = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        out_valid;
  logic [63:0] result;
  logic        flag_overflow, flag_equal, flag_not_equal, flag_greater, flag_less;
  logic        flag_u_equal, flag_u_greater, flag_u_less;

  int n_vec  = 0;
  int n_fail = 0;

  // expected output state
  logic        exp_valid = 1'b0;
  logic [63:0] exp_result = '0;
  logic [7:0]  exp_flags = '0;  // {ovf, eq, ne, gt, lt, ueq, ugt, ult}

  rv64_alu_reg #(.WORDSIZE(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .input_a(input_a), .input_b(input_b), .funct3(funct3), .funct7(funct7),
    .out_valid(out_valid), .result(result),
    .flag_overflow(flag_overflow), .flag_equal(flag_equal),
    .flag_not_equal(flag_not_equal), .flag_greater(flag_greater),
    .flag_less(flag_less), .flag_u_equal(flag_u_equal),
    .flag_u_greater(flag_u_greater), .flag_u_less(flag_u_less)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Signed order via offset binary: flipping the sign bit maps signed order to unsigned.
  function automatic logic s_less(input logic [63:0] a, input logic [63:0] b);
    return (a ^ 64'h8000_0000_0000_0000) < (b ^ 64'h8000_0000_0000_0000);
  endfunction

  function automatic logic [63:0] shift_right(input logic [63:0] a, input int sh, input logic arith);
    logic [63:0] r;
    for (int i = 0; i < 64; i++)
      r[i] = (i + sh < 64) ? a[i + sh] : (arith ? a[63] : 1'b0);
    return r;
  endfunction

  // Returns {overflow, result}
  function automatic logic [64:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7);
    logic [64:0] wide;
    int sh;
    sh = int'(b[5:0]);
    case (f3)
      3'd0: begin
        // 65-bit signed arithmetic: overflow iff the true value does not fit in 64 bits
        if (f7[5]) wide = {a[63], a} - {b[63], b};
        else       wide = {a[63], a} + {b[63], b};
        return {wide[64] != wide[63], wide[63:0]};
      end
      3'd1: return {1'b0, a * (64'd1 << sh)};
      3'd2: return {1'b0, 63'd0, s_less(a, b)};
      3'd3: return {1'b0, 63'd0, a < b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, shift_right(a, sh, f7[5])};
      3'd6: return {1'b0, a | b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  task automatic step(input logic rst, input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] f3, input logic [6:0] f7);
    logic [64:0] r;
    logic lt, ult, eq;
    reset = rst; in_valid = v; input_a = a; input_b = b; funct3 = f3; funct7 = f7;
    @(posedge clk);
    if (rst) begin
      exp_valid = 1'b0; exp_result = '0; exp_flags = '0;
    end else begin
      exp_valid = v;
      if (v) begin
        r   = ref_op(a, b, f3, f7);
        eq  = (a == b);
        lt  = s_less(a, b);
        ult = (a < b);
        exp_result = r[63:0];
        exp_flags  = {r[64], eq, !eq, s_less(b, a), lt, eq, b < a, ult};
      end
    end
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
    check("result", result, exp_result);
    check("flags", {56'd0, flag_overflow, flag_equal, flag_not_equal, flag_greater, flag_less,
                    flag_u_equal, flag_u_greater, flag_u_less}, {56'd0, exp_flags});
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 64'h0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] a, b;
    // Reset for 2 cycles with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), 7'($urandom));

    // ADD overflow
    step(1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b000, 7'b0000000);
    check("add_ovf_result", result, 64'h8000_0000_0000_0000);
    check("add_ovf_flag", {63'd0, flag_overflow}, 64'd1);
    // SUB
    step(1'b0, 1'b1, 64'd5, 64'd7, 3'b000, 7'b0100000);
    check("sub_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    // Signed vs unsigned compare
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 7'd0);
    check("slt_result", result, 64'd1);
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b011, 7'd0);
    check("sltu_result", result, 64'd0);
    // Shifts (upper bits of b ignored)
    step(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h43, 3'b101, 7'd0);
    check("srl_result", result, 64'h1000_0000_0000_0000);
    step(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h43, 3'b101, 7'b0100000);
    check("sra_result", result, 64'hF000_0000_0000_0000);
    step(1'b0, 1'b1, 64'd1, 64'h43, 3'b001, 7'd0);
    check("sll_result", result, 64'h8);
    step(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFC0, 3'b101, 7'b0100000);
    // Ignored funct7 bits / funct7[5] on ops that don't use it
    step(1'b0, 1'b1, 64'hF0F0, 64'h0FF0, 3'b000, 7'b1011111);
    step(1'b0, 1'b1, 64'hF0F0, 64'h0FF0, 3'b100, 7'b0100000);
    // Throughput then hold
    step(1'b0, 1'b1, 64'hF0F0, 64'h0FF0, 3'b100, 7'd0);
    step(1'b0, 1'b1, 64'hF0F0, 64'h0FF0, 3'b110, 7'd0);
    step(1'b0, 1'b1, 64'hF0F0, 64'h0FF0, 3'b111, 7'd0);
    step(1'b0, 1'b1, 64'hF0F0, 64'h0FF0, 3'b000, 7'd0);
    check("b2b_add_result", result, 64'h100E0);
    step(1'b0, 1'b0, 64'd3, 64'd9, 3'b100, 7'd0);
    step(1'b0, 1'b0, 64'd7, 64'd7, 3'b001, 7'd0);
    check("hold_result", result, 64'h100E0);
    // Reset has priority over in_valid
    step(1'b1, 1'b1, 64'd3, 64'd3, 3'b110, 7'd0);

    // Randomized
    for (int i = 0; i < 400; i++) begin
      a = rnd_op();
      b = ($urandom_range(0, 7) == 0) ? a : rnd_op();
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), a, b,
           3'($urandom), 7'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
